// File: rtl/aud_ctrl_fsm.sv
// aud_ctrl_fsm: WM8731 record/playback transport controller.
// Ports:
//    i_clk, i_rst                  clock, async active-high reset
//    i_key_rec/play/stop           one-cycle debounced key pulses
//    i_speed, i_mode               requested playback speed and interpolation mode
//    i_init_done                   I2C initialiser finished (level)
//    i_rec_addr, i_play_addr       recorder write / DSP read addresses
//    o_init_start                  one-cycle start to the I2C initialiser
//    o_rec_*, o_play_*             one-cycle command pulses to recorder and player
//    o_speed, o_mode               speed and mode latched on entry to PLAY
//    o_rec_len, o_full             recorded length, sticky end-of-memory flag
//    o_state                       registered state encoding
module aud_ctrl_fsm #(
   parameter int ADDR_W    = 20,
   parameter int SPEED_W   = 4,
   parameter int MAX_SPEED = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_key_rec,
   input  logic               i_key_play,
   input  logic               i_key_stop,
   input  logic [SPEED_W-1:0] i_speed,
   input  logic [1:0]         i_mode,
   input  logic               i_init_done,
   input  logic [ADDR_W-1:0]  i_rec_addr,
   input  logic [ADDR_W-1:0]  i_play_addr,
   output logic               o_init_start,
   output logic               o_rec_start,
   output logic               o_rec_pause,
   output logic               o_rec_stop,
   output logic               o_play_start,
   output logic               o_play_pause,
   output logic               o_play_stop,
   output logic               o_play_done,
   output logic [SPEED_W-1:0] o_speed,
   output logic [1:0]         o_mode,
   output logic [ADDR_W-1:0]  o_rec_len,
   output logic               o_full,
   output logic [2:0]         o_state
);
   typedef enum logic [2:0] {
      INIT       = 3'd0,
      IDLE       = 3'd1,
      RECD       = 3'd2,
      RECD_PAUSE = 3'd3,
      PLAY       = 3'd4,
      PLAY_PAUSE = 3'd5
   } state_t;
   localparam logic [ADDR_W-1:0]  LAST_ADDR = '1;
   localparam logic [SPEED_W-1:0] SPD_ONE   = SPEED_W'(1);
   localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(MAX_SPEED);
   state_t             state_q;
   logic               init_sent_q;
   logic [SPEED_W-1:0] speed_d;
   logic               mem_full;
   logic               play_end;
   // normal mode always runs at unity; otherwise clamp into 1..MAX_SPEED
   assign speed_d  = (i_mode == 2'd0 || i_speed == '0) ? SPD_ONE :
                     (i_speed > SPD_MAX) ? SPD_MAX : i_speed;
   assign mem_full = i_rec_addr == LAST_ADDR;
   assign play_end = i_play_addr >= o_rec_len && !(i_key_rec || i_key_play || i_key_stop);
   assign o_state  = state_q;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= INIT;
         init_sent_q  <= 1'b0;
         o_init_start <= 1'b0;
         o_rec_start  <= 1'b0;
         o_rec_pause  <= 1'b0;
         o_rec_stop   <= 1'b0;
         o_play_start <= 1'b0;
         o_play_pause <= 1'b0;
         o_play_stop  <= 1'b0;
         o_play_done  <= 1'b0;
         o_speed      <= SPD_ONE;
         o_mode       <= 2'd0;
         o_rec_len    <= '0;
         o_full       <= 1'b0;
      end else begin
         o_init_start <= !init_sent_q;
         init_sent_q  <= 1'b1;
         o_rec_start  <= 1'b0;
         o_rec_pause  <= 1'b0;
         o_rec_stop   <= 1'b0;
         o_play_start <= 1'b0;
         o_play_pause <= 1'b0;
         o_play_stop  <= 1'b0;
         o_play_done  <= 1'b0;
         case (state_q)
            INIT: if (i_init_done) state_q <= IDLE;
            IDLE: begin
               if (i_key_rec) begin
                  state_q     <= RECD;
                  o_rec_start <= 1'b1;
                  o_rec_len   <= '0;
                  o_full      <= 1'b0;
               end else if (i_key_play && o_rec_len != '0) begin
                  state_q      <= PLAY;
                  o_play_start <= 1'b1;
                  o_speed      <= speed_d;
                  o_mode       <= i_mode;
               end
            end
            // hitting the last word stops recording even if a stop key coincides
            RECD: begin
               if (i_key_stop || mem_full) begin
                  state_q    <= IDLE;
                  o_rec_stop <= 1'b1;
                  o_rec_len  <= i_rec_addr;
                  o_full     <= mem_full;
               end else if (i_key_rec) begin
                  state_q     <= RECD_PAUSE;
                  o_rec_pause <= 1'b1;
               end
            end
            RECD_PAUSE: begin
               if (i_key_stop) begin
                  state_q    <= IDLE;
                  o_rec_stop <= 1'b1;
                  o_rec_len  <= i_rec_addr;
               end else if (i_key_rec) begin
                  state_q     <= RECD;
                  o_rec_start <= 1'b1;
               end
            end
            PLAY: begin
               if (i_key_stop) begin
                  state_q     <= IDLE;
                  o_play_stop <= 1'b1;
               end else if (i_key_play) begin
                  state_q      <= PLAY_PAUSE;
                  o_play_pause <= 1'b1;
               end else if (play_end) begin
                  state_q     <= IDLE;
                  o_play_stop <= 1'b1;
                  o_play_done <= 1'b1;
               end
            end
            PLAY_PAUSE: begin
               if (i_key_stop) begin
                  state_q     <= IDLE;
                  o_play_stop <= 1'b1;
               end else if (i_key_play) begin
                  state_q      <= PLAY;
                  o_play_start <= 1'b1;
                  o_speed      <= speed_d;
                  o_mode       <= i_mode;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aud_ctrl_fsm.sv
// tb_aud_ctrl_fsm: directed scoreboard bench for aud_ctrl_fsm.
module tb_aud_ctrl_fsm;
   localparam logic [7:0] INIT_ST = 8'h80, REC_ST = 8'h40, REC_PA = 8'h20, REC_SP = 8'h10;
   localparam logic [7:0] PLY_ST = 8'h08, PLY_PA = 8'h04, PLY_SP = 8'h02, PLY_DN = 8'h01;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_rec = 1'b0, key_play = 1'b0, key_stop = 1'b0;
   logic [3:0]  speed = 4'd1;
   logic [1:0]  mode = 2'd0;
   logic        init_done = 1'b0;
   logic [19:0] rec_addr = '0, play_addr = '0;
   logic        init_start, rec_start, rec_pause, rec_stop;
   logic        play_start, play_pause, play_stop, play_done;
   logic [3:0]  o_speed;
   logic [1:0]  o_mode;
   logic [19:0] rec_len;
   logic        full;
   logic [2:0]  state;
   logic [10:0] exp_q[$];
   int          checks = 0, passed = 0, step = 0;
   aud_ctrl_fsm #(.ADDR_W(20), .SPEED_W(4), .MAX_SPEED(8)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_key_rec(key_rec), .i_key_play(key_play), .i_key_stop(key_stop),
      .i_speed(speed), .i_mode(mode), .i_init_done(init_done),
      .i_rec_addr(rec_addr), .i_play_addr(play_addr),
      .o_init_start(init_start), .o_rec_start(rec_start), .o_rec_pause(rec_pause),
      .o_rec_stop(rec_stop), .o_play_start(play_start), .o_play_pause(play_pause),
      .o_play_stop(play_stop), .o_play_done(play_done),
      .o_speed(o_speed), .o_mode(o_mode), .o_rec_len(rec_len), .o_full(full),
      .o_state(state)
   );
   always #5 clk = ~clk;
   initial begin
      #100000;
      $display("FAIL watchdog expired at step %0d", step);
      $fatal(1, "watchdog");
   end
   function automatic logic [10:0] ev(input logic [2:0] s, input logic [7:0] p);
      return {s, p};
   endfunction
   function automatic logic [10:0] obs();
      return {state, init_start, rec_start, rec_pause, rec_stop,
              play_start, play_pause, play_stop, play_done};
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) passed++;
      else $error("FAIL %s step %0d observed=%0h expected=%0h", tag, step, got, want);
   endtask
   task automatic cyc(input logic r, input logic p, input logic s, input logic [10:0] e);
      key_rec  = r;
      key_play = p;
      key_stop = s;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      key_rec  = 1'b0;
      key_play = 1'b0;
      key_stop = 1'b0;
      step++;
      chk("state_pulses", 32'(obs()), 32'(exp_q.pop_front()));
   endtask
   initial begin
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_vec", 32'(obs()), 32'(ev(3'd0, 8'h00)));
      chk("rst_speed", 32'(o_speed), 32'd1);
      chk("rst_mode", 32'(o_mode), 32'd0);
      chk("rst_len", 32'(rec_len), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      rst = 1'b0;
      cyc(0, 0, 0, ev(3'd0, INIT_ST));
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, ev(3'd0, 8'h00));
      cyc(1, 0, 0, ev(3'd0, 8'h00));
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, ev(3'd0, 8'h00));
      init_done = 1'b1;
      cyc(0, 0, 0, ev(3'd1, 8'h00));
      cyc(0, 1, 0, ev(3'd1, 8'h00));
      cyc(0, 0, 1, ev(3'd1, 8'h00));
      cyc(1, 0, 0, ev(3'd2, REC_ST));
      cyc(0, 0, 0, ev(3'd2, 8'h00));
      cyc(0, 1, 0, ev(3'd2, 8'h00));
      rec_addr = 20'h00123;
      cyc(0, 0, 1, ev(3'd1, REC_SP));
      chk("len_123", 32'(rec_len), 32'h123);
      chk("full_0", 32'(full), 32'd0);
      cyc(1, 0, 0, ev(3'd2, REC_ST));
      chk("len_clr", 32'(rec_len), 32'd0);
      rec_addr = 20'h00010;
      cyc(1, 0, 1, ev(3'd1, REC_SP));
      chk("len_10", 32'(rec_len), 32'h10);
      cyc(1, 0, 0, ev(3'd2, REC_ST));
      cyc(1, 0, 0, ev(3'd3, REC_PA));
      cyc(0, 1, 0, ev(3'd3, 8'h00));
      cyc(1, 0, 0, ev(3'd2, REC_ST));
      rec_addr = 20'hFFFFF;
      cyc(0, 0, 0, ev(3'd1, REC_SP));
      chk("len_full", 32'(rec_len), 32'hFFFFF);
      chk("full_1", 32'(full), 32'd1);
      rec_addr = 20'h00000;
      cyc(1, 0, 0, ev(3'd2, REC_ST));
      chk("full_clr", 32'(full), 32'd0);
      chk("len_clr2", 32'(rec_len), 32'd0);
      rec_addr = 20'h00040;
      cyc(1, 0, 0, ev(3'd3, REC_PA));
      cyc(0, 0, 1, ev(3'd1, REC_SP));
      chk("len_40", 32'(rec_len), 32'h40);
      speed = 4'd12;
      mode  = 2'd1;
      cyc(0, 1, 0, ev(3'd4, PLY_ST));
      chk("spd_sat", 32'(o_speed), 32'd8);
      chk("mode_1", 32'(o_mode), 32'd1);
      speed = 4'd3;
      cyc(0, 0, 0, ev(3'd4, 8'h00));
      chk("spd_hold", 32'(o_speed), 32'd8);
      play_addr = 20'h00020;
      cyc(0, 1, 0, ev(3'd5, PLY_PA));
      play_addr = 20'h00040;
      cyc(0, 0, 0, ev(3'd5, 8'h00));
      speed = 4'd0;
      cyc(0, 1, 0, ev(3'd4, PLY_ST));
      chk("spd_zero", 32'(o_speed), 32'd1);
      cyc(0, 0, 0, ev(3'd1, PLY_SP | PLY_DN));
      play_addr = 20'h00000;
      speed = 4'd5;
      mode  = 2'd0;
      cyc(0, 1, 0, ev(3'd4, PLY_ST));
      chk("spd_norm", 32'(o_speed), 32'd1);
      chk("mode_0", 32'(o_mode), 32'd0);
      speed = 4'd6;
      mode  = 2'd3;
      cyc(0, 1, 0, ev(3'd5, PLY_PA));
      cyc(0, 1, 0, ev(3'd4, PLY_ST));
      chk("spd_6", 32'(o_speed), 32'd6);
      chk("mode_3", 32'(o_mode), 32'd3);
      cyc(1, 0, 0, ev(3'd4, 8'h00));
      cyc(0, 0, 1, ev(3'd1, PLY_SP));
      cyc(0, 1, 0, ev(3'd4, PLY_ST));
      rst = 1'b1;
      #1;
      chk("abort_vec", 32'(obs()), 32'(ev(3'd0, 8'h00)));
      chk("abort_len", 32'(rec_len), 32'd0);
      chk("abort_spd", 32'(o_speed), 32'd1);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/aud_ctrl_fsm.md
Name: aud_ctrl_fsm

Overview:
- Parametrised top-level transport controller for the WM8731 record/playback path.
- Sequences codec I2C initialisation, then arbitrates record, play, pause and stop keys.
- Drives one-cycle command pulses to the recorder and the DSP/player, latches playback speed and interpolation mode, and tracks recorded length.
- New relative to the previous controller: it auto-stops recording when memory is full and auto-stops playback at the end of the recording.

Parameters:
ADDR_W, 20, SRAM word-address width; memory depth is 2**ADDR_W words.
SPEED_W, 4, width of the speed selector.
MAX_SPEED, 8, largest legal speed factor; larger requests saturate to this value.

Ports:
i_clk  in  1  system clock (the audio bit clock domain); all logic on the rising edge.
i_rst  in  1  reset, asynchronous, active-high.
i_key_rec  in  1  record/pause key, already debounced, one-cycle pulse.
i_key_play  in  1  play/pause key, one-cycle pulse.
i_key_stop  in  1  stop key, one-cycle pulse.
i_speed  in  SPEED_W  requested speed factor.
i_mode  in  2  0 normal, 1 fast, 2 slow with constant interpolation, 3 slow with linear interpolation.
i_init_done  in  1  I2C initialiser finished (level).
i_rec_addr  in  ADDR_W  current recorder write address.
i_play_addr  in  ADDR_W  current DSP read address.
o_init_start  out  1  one-cycle start to the I2C initialiser.
o_rec_start  out  1  one-cycle pulse: start or resume recording.
o_rec_pause  out  1  one-cycle pulse: pause recording.
o_rec_stop  out  1  one-cycle pulse: stop recording.
o_play_start  out  1  one-cycle pulse: start or resume playback.
o_play_pause  out  1  one-cycle pulse: pause playback.
o_play_stop  out  1  one-cycle pulse: stop playback.
o_play_done  out  1  one-cycle pulse: playback reached end of recording.
o_speed  out  SPEED_W  latched speed, range 1..MAX_SPEED.
o_mode  out  2  latched mode.
o_rec_len  out  ADDR_W  number of valid recorded words.
o_full  out  1  sticky: last recording hit end of memory.
o_state  out  3  current state encoding.

Behaviour:
- States and encodings: INIT=0, IDLE=1, RECD=2, RECD_PAUSE=3, PLAY=4, PLAY_PAUSE=5. Encodings 6 and 7 return to IDLE on the next cycle.
- Reset values: state INIT; every pulse output 0; o_speed 1; o_mode 0; o_rec_len 0; o_full 0. Reset mid-operation aborts immediately with no stop pulse.
- All outputs are registered. A pulse is high in the same cycle the new state first appears, i.e. one cycle after the key cycle.
- INIT:
  - o_init_start pulses exactly once, in the first clock after reset deasserts.
  - Stay in INIT until i_init_done=1, then go to IDLE.
  - All keys are ignored in INIT.
- Key priority when keys arrive in the same cycle: stop > rec > play. Only one action is taken per cycle.
- IDLE:
  - rec: go to RECD; pulse o_rec_start; clear o_rec_len and o_full.
  - play with o_rec_len != 0: go to PLAY; pulse o_play_start; latch speed and mode.
  - play with o_rec_len == 0: ignored.
  - stop: ignored.
- RECD:
  - stop: go to IDLE; pulse o_rec_stop; o_rec_len <= i_rec_addr.
  - rec: go to RECD_PAUSE; pulse o_rec_pause.
  - play: ignored.
  - Auto-stop when i_rec_addr == 2**ADDR_W-1 and no stop key: go to IDLE; pulse o_rec_stop; o_rec_len <= 2**ADDR_W-1; o_full <= 1. If stop arrives in the same cycle, handle as a plain stop with o_full=1.
- RECD_PAUSE:
  - rec: go to RECD; pulse o_rec_start. o_rec_len is not cleared.
  - stop: go to IDLE; pulse o_rec_stop; o_rec_len <= i_rec_addr.
  - play: ignored.
- PLAY:
  - stop: go to IDLE; pulse o_play_stop.
  - play: go to PLAY_PAUSE; pulse o_play_pause.
  - End of recording when i_play_addr >= o_rec_len and no key: go to IDLE; pulse o_play_stop and o_play_done together.
  - rec: ignored.
- PLAY_PAUSE:
  - play: go to PLAY; pulse o_play_start; re-latch speed and mode.
  - stop: go to IDLE; pulse o_play_stop.
  - The end-of-recording check is inactive in this state.
- Speed latch:
  - Update only when entering PLAY.
  - i_speed == 0 latches 1; i_speed > MAX_SPEED latches MAX_SPEED.
  - i_mode == 0 forces o_speed to 1.
  - Changing i_speed or i_mode during PLAY has no effect.
- o_state always reflects the registered state.

Test Plan:
- Reset, then i_init_done=1 at cycle 10 -> o_init_start high for exactly cycle 1; o_state=1 at cycle 11; a rec key at cycle 5 produces no response.
- IDLE: rec, wait, stop with i_rec_addr=0x00123 -> o_rec_start then o_rec_stop; o_rec_len=0x00123; o_full=0; o_state=1.
- ADDR_W=4: record until i_rec_addr=15 -> o_rec_stop pulse, o_rec_len=15, o_full=1. A new rec clears o_full and o_rec_len.
- Play with i_speed=12, i_mode=1 -> o_speed=8. Repeat with i_speed=0 -> 1. Repeat with i_mode=0, i_speed=5 -> 1. Changing i_speed mid-play leaves o_speed unchanged.
- o_rec_len=0x40; play until i_play_addr=0x40 -> o_play_stop and o_play_done in the same cycle; o_state=1. Pause at 0x20 with addr advanced to 0x40 -> no auto-stop.
- rec+stop keys in the same cycle in RECD -> stop only (o_rec_stop, no o_rec_pause). Play with o_rec_len=0 -> no pulse, remains in IDLE.
